// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// rx_frame_buffer : receive FIFO that exposes bytes only after a commit byte,
//                   with abort, inter-byte timeout and overflow rollback.
// Revision        : 1.0
// ============================================================================
module rx_frame_buffer #(
  parameter int         DEPTH       = 8,
  parameter int         AW          = 3,
  parameter logic [7:0] COMMIT_CODE = 8'hFF,
  parameter logic [7:0] ABORT_CODE  = 8'h1B,
  parameter int         TIMEOUT     = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_empty,
  output logic [15:0]   disp_code,
  output logic          disp_update,
  output logic [AW:0]   frame_len,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  logic [7:0]    mem [DEPTH];

  state_t        state_q, state_d;
  logic          rx_valid_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cm_ptr_q, cm_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    prev_q, prev_d;
  logic [15:0]   disp_code_q, disp_code_d;
  logic [AW:0]   frame_len_q, frame_len_d;
  logic          overflow_q, overflow_d;
  logic          disp_update_q, disp_update_d;
  logic          timeout_err_q, timeout_err_d;

  logic          accept, full, empty, wr_en, is_commit, is_abort;

  always_comb begin
    accept        = rx_valid & ~rx_valid_q;
    full          = (wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH);
    empty         = (rd_ptr_q == cm_ptr_q);
    is_commit     = (rx_data == COMMIT_CODE);
    is_abort      = (rx_data == ABORT_CODE);

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cm_ptr_d      = cm_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    last_d        = last_q;
    prev_d        = prev_q;
    disp_code_d   = disp_code_q;
    frame_len_d   = frame_len_q;
    overflow_d    = overflow_q;
    disp_update_d = 1'b0;
    timeout_err_d = 1'b0;
    wr_en         = 1'b0;
    tmo_cnt_d     = (state_q == S_IDLE) ? '0 : tmo_cnt_q + 1'b1;

    if (accept) begin
      tmo_cnt_d = '0;
      if (is_abort) begin
        wr_ptr_d = cm_ptr_q;
        state_d  = S_IDLE;
      end else if (is_commit) begin
        case (state_q)
          S_COLLECT: begin
            cm_ptr_d      = wr_ptr_q;
            frame_len_d   = wr_ptr_q - cm_ptr_q;
            disp_code_d   = {prev_q, last_q};
            disp_update_d = 1'b1;
            state_d       = S_IDLE;
          end
          S_DROP: begin
            wr_ptr_d   = cm_ptr_q;
            overflow_d = 1'b1;
            state_d    = S_IDLE;
          end
          default: ;
        endcase
      end else if (state_q != S_DROP) begin
        if (full) begin
          state_d = S_DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = S_COLLECT;
          last_d   = rx_data;
          // The first byte of a frame has no predecessor, so the high half reads 00.
          prev_d   = (state_q == S_IDLE) ? 8'h00 : last_q;
        end
      end
    end else if (state_q != S_IDLE && tmo_cnt_q == CW'(TIMEOUT - 1)) begin
      wr_ptr_d      = cm_ptr_q;
      timeout_err_d = 1'b1;
      state_d       = S_IDLE;
      tmo_cnt_d     = '0;
      if (state_q == S_DROP) overflow_d = 1'b1;
    end

    if (rd_en && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_valid_q    <= 1'b0;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tmo_cnt_q     <= '0;
      last_q        <= 8'h00;
      prev_q        <= 8'h00;
      disp_code_q   <= 16'h0000;
      frame_len_q   <= '0;
      overflow_q    <= 1'b0;
      disp_update_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tmo_cnt_q     <= tmo_cnt_d;
      last_q        <= last_d;
      prev_q        <= prev_d;
      disp_code_q   <= disp_code_d;
      frame_len_q   <= frame_len_d;
      overflow_q    <= overflow_d;
      disp_update_q <= disp_update_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: visibility is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  assign rd_data     = mem[rd_ptr_q[AW-1:0]];
  assign rd_empty    = empty;
  assign disp_code   = disp_code_q;
  assign disp_update = disp_update_q;
  assign frame_len   = frame_len_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_rx_frame_buffer : directed and randomized checks of rx_frame_buffer
//                      against a queue-based frame model.
// Revision           : 1.0
// ============================================================================
module tb_rx_frame_buffer;

  localparam int         DEPTH   = 8;
  localparam int         AW      = 3;
  localparam int         TIMEOUT = 40;
  localparam logic [7:0] COMMIT  = 8'hFF;
  localparam logic [7:0] ABORT   = 8'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_empty;
  logic [15:0] disp_code;
  logic        disp_update;
  logic [AW:0] frame_len;
  logic        overflow;
  logic        timeout_err;

  rx_frame_buffer #(
    .DEPTH(DEPTH), .AW(AW), .COMMIT_CODE(COMMIT), .ABORT_CODE(ABORT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rd_en(rd_en),
    .rd_data(rd_data), .rd_empty(rd_empty), .disp_code(disp_code),
    .disp_update(disp_update), .frame_len(frame_len), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: committed-but-unread bytes, bytes of the open frame, and a drop flag.
  logic [7:0]  q_cm[$];
  logic [7:0]  q_fr[$];
  bit          m_drop, m_ovf, exp_upd, exp_to;
  logic [15:0] m_disp;
  int          m_len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_empty", 32'(rd_empty), 32'(q_cm.size() == 0));
    if (q_cm.size() > 0) chk("rd_data", 32'(rd_data), 32'(q_cm[0]));
    chk("disp_code", 32'(disp_code), 32'(m_disp));
    chk("frame_len", 32'(frame_len), 32'(m_len));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("disp_update", 32'(disp_update), 32'(exp_upd));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
  endtask

  task automatic model_reset();
    q_cm.delete();
    q_fr.delete();
    m_drop = 0; m_ovf = 0; m_disp = 16'h0000; m_len = 0;
    exp_upd = 0; exp_to = 0;
  endtask

  task automatic model_accept(input logic [7:0] b, input bit rd);
    bit pre_empty, is_full;
    pre_empty = (q_cm.size() == 0);
    is_full   = (q_cm.size() + q_fr.size() == DEPTH);
    exp_upd   = 0;
    if (b == COMMIT) begin
      if (m_drop) begin
        q_fr.delete(); m_ovf = 1; m_drop = 0;
      end else if (q_fr.size() > 0) begin
        m_len  = q_fr.size();
        m_disp = (q_fr.size() >= 2) ? {q_fr[q_fr.size()-2], q_fr[q_fr.size()-1]}
                                    : {8'h00, q_fr[0]};
        foreach (q_fr[i]) q_cm.push_back(q_fr[i]);
        q_fr.delete();
        exp_upd = 1;
      end
    end else if (b == ABORT) begin
      q_fr.delete(); m_drop = 0;
    end else if (!m_drop) begin
      if (is_full) m_drop = 1;
      else q_fr.push_back(b);
    end
    if (rd && !pre_empty) void'(q_cm.pop_front());
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rd);
    rx_data = b; rx_valid = 1'b1; rd_en = rd;
    tick();
    model_accept(b, rd);
    rd_en = 1'b0; rx_valid = 1'b0;
    check_all();
    tick();
    exp_upd = 0;
    check_all();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    if (q_cm.size() > 0) void'(q_cm.pop_front());
    rd_en = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check_all();

    // Basic two-byte frame, then drain it.
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(COMMIT, 0);
    pop(); pop(); pop();

    // Abort discards the open frame; a 1-byte frame follows.
    send_byte(8'h56, 0); send_byte(ABORT, 0);
    send_byte(8'h78, 0); send_byte(COMMIT, 0);
    pop();

    // Holding rx_valid high delivers a single byte.
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick(); model_accept(8'h5A, 0); check_all();
    tick(); tick(); check_all();
    rx_valid = 1'b0; tick();
    send_byte(COMMIT, 0);
    pop();

    // Overflow: nine data bytes into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 0);
    send_byte(COMMIT, 0);
    send_byte(8'hAA, 0); send_byte(COMMIT, 0);
    pop();

    // Inter-byte timeout discards the open frame.
    send_byte(8'h42, 0);
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      tick();
      check_all();
    end
    tick();
    q_fr.delete(); m_drop = 0; exp_to = 1;
    check_all();
    tick();
    exp_to = 0;
    check_all();
    send_byte(COMMIT, 0);

    // Three 3-byte frames, each drained, carrying the pointers past the wrap.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 3; k++) send_byte(8'(8'h20 + 8'(f * 3 + k)), 0);
      send_byte(COMMIT, 0);
      pop(); pop(); pop();
      pop();
    end

    // Randomized traffic with occasional same-cycle pops.
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [7:0] b;
      op = $urandom_range(0, 11);
      if (op <= 6) begin
        b = 8'($urandom_range(0, 8'hFE));
        if (b == ABORT) b = 8'h1C;
        send_byte(b, $urandom_range(0, 3) == 0);
      end else if (op <= 8) begin
        send_byte(COMMIT, $urandom_range(0, 1) == 0);
      end else if (op == 9) begin
        send_byte(($urandom_range(0, 3) == 0) ? ABORT : COMMIT, 0);
      end else begin
        pop();
      end
    end

    // Reset in the middle of a frame with committed data present.
    send_byte(8'hC1, 0); send_byte(8'hC2, 0); send_byte(COMMIT, 0);
    send_byte(8'hC3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_all();
    send_byte(8'hD4, 0); send_byte(COMMIT, 0);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Sits directly downstream of the serial receiver; consumes its byte and level-valid pair.
- Groups received bytes into frames terminated by a commit byte and holds frame bytes in a FIFO. Readers see a frame's bytes only after it has been committed.
- On each commit, drives a 16-bit display code, built from the last two frame bytes, to the eight-segment display stage.
- Handles abort bytes, inter-byte timeout and FIFO overflow by rolling back the uncommitted frame.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2.
- AW, 3, log2(DEPTH); pointers are AW+1 bits wide.
- COMMIT_CODE, 8'hFF, byte that ends and commits a frame; it is not stored.
- ABORT_CODE, 8'h1B, byte that discards the uncommitted frame; it is not stored.
- TIMEOUT, 50000, clk cycles allowed between bytes inside a frame before the frame is discarded.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high. Single clock domain.
- rx_data  in  8  received byte from the serial receiver.
- rx_valid  in  1  level from the receiver, high while rx_data is valid. Each rising edge delivers one byte.
- rd_en  in  1  pop one committed byte.
- rd_data  out  8  committed byte at the head of the FIFO; first-word-fall-through.
- rd_empty  out  1  no committed bytes available.
- disp_code  out  16  display code of the last committed non-empty frame.
- disp_update  out  1  one-cycle pulse when disp_code changes.
- frame_len  out  AW+1  byte count of the last committed frame.
- overflow  out  1  sticky; set when a frame is lost to a full FIFO.
- timeout_err  out  1  one-cycle pulse when a frame is discarded by timeout.

Behaviour:
- Reset
  - All pointers 0, state IDLE, timeout counter 0.
  - disp_code=0, frame_len=0, overflow=0, disp_update=0, timeout_err=0, rd_empty=1.
  - Reset mid-frame discards everything, including committed bytes.
- Byte acceptance
  - A byte is accepted in the cycle where rx_valid=1 and the registered rx_valid from the previous cycle was 0; rx_data is sampled in that cycle.
  - All effects of an accepted byte are visible on the next cycle. Holding rx_valid high yields exactly one byte.
- Pointers
  - wr_ptr: next write slot.
  - cm_ptr: end of committed data.
  - rd_ptr: read head.
  - occupancy = wr_ptr - rd_ptr, computed modulo 2^(AW+1); full when occupancy == DEPTH.
  - rd_empty = (rd_ptr == cm_ptr).
  - rd_data = mem[rd_ptr[AW-1:0]].
- States
  - IDLE: no uncommitted bytes.
  - COLLECT: frame in progress.
  - DROP: frame has overflowed.
- Data byte (not COMMIT_CODE or ABORT_CODE)
  - In IDLE or COLLECT with the FIFO not full: write the byte, increment wr_ptr, go to COLLECT.
  - If the FIFO is full: do not write, go to DROP.
  - In DROP: the byte is ignored.
- COMMIT_CODE
  - COLLECT:
    - Set cm_ptr=wr_ptr and frame_len = wr_ptr - cm_ptr, using the old cm_ptr.
    - Set disp_code = {second-last byte, last byte}; a 1-byte frame gives {8'h00, byte}.
    - Pulse disp_update and go to IDLE.
  - IDLE (empty frame): no change, no pulse.
  - DROP: set wr_ptr=cm_ptr, set overflow=1, go to IDLE. disp_code is unchanged.
- ABORT_CODE, any state: set wr_ptr=cm_ptr and go to IDLE. No flags change.
- Timeout
  - The counter clears on every accepted byte and in IDLE, and increments each cycle in COLLECT or DROP.
  - When it reaches TIMEOUT-1 with no byte accepted: set wr_ptr=cm_ptr, pulse timeout_err, go to IDLE. A DROP frame lost this way also sets overflow.
- Read
  - rd_en with rd_empty=0 increments rd_ptr. rd_en with rd_empty=1 is ignored, with no underflow.
  - full and rd_empty are evaluated on registered pointers. A pop in the same cycle as a write to a full FIFO does not make room for that write.
  - A commit and a pop in the same cycle are both applied; rd_empty reflects both on the next cycle.
- Wrap-around: pointers wrap modulo 2^(AW+1). Only the low AW bits index mem.

Test Plan:
- Pulse in 8'h12, 8'h34, 8'hFF.
  -> disp_code=16'h1234, disp_update high for 1 cycle, frame_len=2, rd_empty=0. Pops return 12, then 34, then rd_empty=1.
- Pulse in 8'h56, 8'h1B, then 8'h78, 8'hFF.
  -> Only 8'h78 is readable, disp_code=16'h0078, frame_len=1.
- With DEPTH=8, send 9 data bytes 01..09 then FF, no reads.
  -> overflow=1, rd_empty=1, disp_code unchanged; a following AA,FF frame commits normally.
- Send 8'h42, then keep rx_valid low for TIMEOUT cycles.
  -> timeout_err pulses once, the byte is discarded, and a later FF produces no disp_update.
- Commit 3 frames of 3 bytes each, popping each frame before sending the next, so the pointers wrap past 8.
  -> Data order is preserved across the wrap; rd_en while empty leaves the pointers unchanged.
- Assert rst for one cycle mid-frame after committing 2 bytes.
  -> All outputs return to their reset values and rd_empty=1.
